battlefront_calc: RTL and testbench

Lane-arbitration stage that sits directly upstream of every player and enemy unit. On each game tick it scans all unit slots and computes the frontmost live unit on each side. It then routes that side's summed attack damage to the opposing frontmost unit only, and issues the single-cycle damage and move strobes that the units consume as `damageSCEN`, `moveSCEN`, `damageIn` and `unitFront`.

---
 rtl/battlefront_calc.sv | 351 +++++++++++++++++++++++++++++++++++
 tb/tb_battlefront_calc.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/battlefront_calc.sv
// battlefront_calc: per-tick lane scan that finds each side's front unit and issues damage/move strobes.
// Optional base-health tracking and game-over detection are enabled with `define BATTLEFRONT_BASE_DMG_EN.
module battlefront_calc #(
    parameter int         NUM_UNITS = 4,
    parameter logic [8:0] FIELD_MAX = 9'd480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   gameClk,
    input  logic [9*NUM_UNITS-1:0] playerPos,
    input  logic [2*NUM_UNITS-1:0] playerType,
    input  logic [8*NUM_UNITS-1:0] playerDmg,
    input  logic [9*NUM_UNITS-1:0] enemyPos,
    input  logic [2*NUM_UNITS-1:0] enemyType,
    input  logic [8*NUM_UNITS-1:0] enemyDmg,
    output logic [8:0]             playerFront,
    output logic [8:0]             enemyFront,
    output logic [7:0]             dmgToPlayer,
    output logic [7:0]             dmgToEnemy,
    output logic [NUM_UNITS-1:0]   playerDamageSCEN,
    output logic [NUM_UNITS-1:0]   enemyDamageSCEN,
    output logic                   moveSCEN,
`ifdef BATTLEFRONT_BASE_DMG_EN
    output logic [7:0]             playerBaseHealth,
    output logic [7:0]             enemyBaseHealth,
    output logic [1:0]             gameOver,
`endif
    output logic                   busy
);

    localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

    typedef enum logic [1:0] {
        QIdle   = 2'd0,
        QScan   = 2'd1,
        QDamage = 2'd2,
        QMove   = 2'd3
    } state_t;

    function automatic logic [9:0] sat_add10(input logic [9:0] acc, input logic [7:0] val);
        logic [10:0] sum;
        sum = {1'b0, acc} + {3'b000, val};
        if (sum[10]) begin
            return 10'h3FF;
        end else begin
            return sum[9:0];
        end
    endfunction

    function automatic logic [7:0] clamp8(input logic [9:0] acc);
        if (acc > 10'd255) begin
            return 8'hFF;
        end else begin
            return acc[7:0];
        end
    endfunction

    function automatic logic [NUM_UNITS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_UNITS-1:0] vec;
        for (int k = 0; k < NUM_UNITS; k++) begin
            vec[k] = (idx == IDX_W'(k));
        end
        return vec;
    endfunction

    state_t                 state_q, state_d;
    logic                   game_clk_q;
    logic                   tick_s, start_s, halt_s;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [8:0]             p_best_q, p_best_d, e_best_q, e_best_d;
    logic [IDX_W-1:0]       p_idx_q, p_idx_d, e_idx_q, e_idx_d;
    logic                   p_found_q, p_found_d, e_found_q, e_found_d;
    logic [9:0]             p_acc_q, p_acc_d, e_acc_q, e_acc_d;
    logic [8:0]             player_front_q, player_front_d, enemy_front_q, enemy_front_d;
    logic [7:0]             dmg_to_player_q, dmg_to_player_d, dmg_to_enemy_q, dmg_to_enemy_d;
    logic [NUM_UNITS-1:0]   p_scen_q, p_scen_d, e_scen_q, e_scen_d;
    logic                   move_q, move_d, busy_q, busy_d;

    logic [8:0]             p_pos_s, e_pos_s;
    logic [7:0]             p_dmg_s, e_dmg_s;
    logic                   p_live_s, e_live_s, p_take_s, e_take_s;
    logic [8:0]             p_best_n_s, e_best_n_s;
    logic [IDX_W-1:0]       p_idx_n_s, e_idx_n_s;
    logic                   p_found_n_s, e_found_n_s;
    logic [9:0]             p_acc_n_s, e_acc_n_s;
    logic [7:0]             dmg_to_enemy_n_s, dmg_to_player_n_s;

`ifdef BATTLEFRONT_BASE_DMG_EN
    function automatic logic [7:0] sub_sat8(input logic [7:0] a, input logic [7:0] b);
        if (b > a) begin
            return 8'd0;
        end else begin
            return a - b;
        end
    endfunction

    logic [7:0] p_health_q, p_health_d, e_health_q, e_health_d;
    logic [1:0] game_over_q, game_over_d;

    assign halt_s = |game_over_q;
`else
    assign halt_s = 1'b0;
`endif

    assign tick_s  = gameClk & ~game_clk_q;
    assign start_s = tick_s & ~halt_s;

    // Slot under scan on both sides.
    always_comb begin
        p_pos_s  = playerPos[9*idx_q +: 9];
        p_live_s = (playerType[2*idx_q +: 2] != 2'b00);
        p_dmg_s  = playerDmg[8*idx_q +: 8];
        e_pos_s  = enemyPos[9*idx_q +: 9];
        e_live_s = (enemyType[2*idx_q +: 2] != 2'b00);
        e_dmg_s  = enemyDmg[8*idx_q +: 8];
    end

    // Best-so-far and damage sums including the current slot; the first live unit always
    // claims the slot so a unit standing on its own base can still receive the strobe.
    always_comb begin
        p_take_s = p_live_s & (~p_found_q | (p_pos_s < p_best_q));
        e_take_s = e_live_s & (~e_found_q | (e_pos_s > e_best_q));
        if (p_take_s) begin
            p_best_n_s = p_pos_s;
            p_idx_n_s  = idx_q;
        end else begin
            p_best_n_s = p_best_q;
            p_idx_n_s  = p_idx_q;
        end
        if (e_take_s) begin
            e_best_n_s = e_pos_s;
            e_idx_n_s  = idx_q;
        end else begin
            e_best_n_s = e_best_q;
            e_idx_n_s  = e_idx_q;
        end
        p_found_n_s = p_found_q | p_live_s;
        e_found_n_s = e_found_q | e_live_s;
        if (p_live_s) begin
            p_acc_n_s = sat_add10(p_acc_q, p_dmg_s);
        end else begin
            p_acc_n_s = p_acc_q;
        end
        if (e_live_s) begin
            e_acc_n_s = sat_add10(e_acc_q, e_dmg_s);
        end else begin
            e_acc_n_s = e_acc_q;
        end
        dmg_to_enemy_n_s  = clamp8(p_acc_n_s);
        dmg_to_player_n_s = clamp8(e_acc_n_s);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            QIdle: begin
                if (start_s) begin
                    state_d = QScan;
                end else begin
                    state_d = QIdle;
                end
            end
            QScan: begin
                if (idx_q == LAST_IDX) begin
                    state_d = QDamage;
                end else begin
                    state_d = QScan;
                end
            end
            QDamage: state_d = QMove;
            QMove:   state_d = QIdle;
            default: state_d = QIdle;
        endcase
    end

    // Scan datapath and registered outputs; results load on the last scan cycle so they show in QDamage.
    always_comb begin
        idx_d           = idx_q;
        p_best_d        = p_best_q;
        e_best_d        = e_best_q;
        p_idx_d         = p_idx_q;
        e_idx_d         = e_idx_q;
        p_found_d       = p_found_q;
        e_found_d       = e_found_q;
        p_acc_d         = p_acc_q;
        e_acc_d         = e_acc_q;
        player_front_d  = player_front_q;
        enemy_front_d   = enemy_front_q;
        dmg_to_player_d = dmg_to_player_q;
        dmg_to_enemy_d  = dmg_to_enemy_q;
        p_scen_d        = {NUM_UNITS{1'b0}};
        e_scen_d        = {NUM_UNITS{1'b0}};
        move_d          = 1'b0;
        case (state_q)
            QIdle: begin
                if (start_s) begin
                    idx_d     = {IDX_W{1'b0}};
                    p_best_d  = FIELD_MAX;
                    e_best_d  = 9'd0;
                    p_idx_d   = {IDX_W{1'b0}};
                    e_idx_d   = {IDX_W{1'b0}};
                    p_found_d = 1'b0;
                    e_found_d = 1'b0;
                    p_acc_d   = 10'd0;
                    e_acc_d   = 10'd0;
                end else begin
                    idx_d = idx_q;
                end
            end
            QScan: begin
                idx_d     = idx_q + IDX_W'(1);
                p_best_d  = p_best_n_s;
                e_best_d  = e_best_n_s;
                p_idx_d   = p_idx_n_s;
                e_idx_d   = e_idx_n_s;
                p_found_d = p_found_n_s;
                e_found_d = e_found_n_s;
                p_acc_d   = p_acc_n_s;
                e_acc_d   = e_acc_n_s;
                if (idx_q == LAST_IDX) begin
                    idx_d           = {IDX_W{1'b0}};
                    player_front_d  = p_best_n_s;
                    enemy_front_d   = e_best_n_s;
                    dmg_to_enemy_d  = dmg_to_enemy_n_s;
                    dmg_to_player_d = dmg_to_player_n_s;
                    if (e_found_n_s && (dmg_to_enemy_n_s != 8'd0)) begin
                        e_scen_d = onehot(e_idx_n_s);
                    end else begin
                        e_scen_d = {NUM_UNITS{1'b0}};
                    end
                    if (p_found_n_s && (dmg_to_player_n_s != 8'd0)) begin
                        p_scen_d = onehot(p_idx_n_s);
                    end else begin
                        p_scen_d = {NUM_UNITS{1'b0}};
                    end
                end else begin
                    player_front_d = player_front_q;
                end
            end
            QDamage: move_d = 1'b1;
            QMove:   move_d = 1'b0;
            default: move_d = 1'b0;
        endcase
        busy_d = (state_d != QIdle);
    end

`ifdef BATTLEFRONT_BASE_DMG_EN
    // Damage aimed at an empty side lands on that side's base.
    always_comb begin
        p_health_d = p_health_q;
        e_health_d = e_health_q;
        if (state_q == QDamage) begin
            if (!e_found_q) begin
                e_health_d = sub_sat8(e_health_q, dmg_to_enemy_q);
            end else begin
                e_health_d = e_health_q;
            end
            if (!p_found_q) begin
                p_health_d = sub_sat8(p_health_q, dmg_to_player_q);
            end else begin
                p_health_d = p_health_q;
            end
        end else begin
            p_health_d = p_health_q;
        end
        game_over_d = game_over_q | {(e_health_d == 8'd0), (p_health_d == 8'd0)};
    end
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= QIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Game-tick history is captured every cycle so a level held through reset is not a new edge.
    always_ff @(posedge clk) begin
        game_clk_q <= gameClk;
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q           <= {IDX_W{1'b0}};
            p_best_q        <= FIELD_MAX;
            e_best_q        <= 9'd0;
            p_idx_q         <= {IDX_W{1'b0}};
            e_idx_q         <= {IDX_W{1'b0}};
            p_found_q       <= 1'b0;
            e_found_q       <= 1'b0;
            p_acc_q         <= 10'd0;
            e_acc_q         <= 10'd0;
            player_front_q  <= FIELD_MAX;
            enemy_front_q   <= 9'd0;
            dmg_to_player_q <= 8'd0;
            dmg_to_enemy_q  <= 8'd0;
            p_scen_q        <= {NUM_UNITS{1'b0}};
            e_scen_q        <= {NUM_UNITS{1'b0}};
            move_q          <= 1'b0;
            busy_q          <= 1'b0;
`ifdef BATTLEFRONT_BASE_DMG_EN
            p_health_q      <= 8'd255;
            e_health_q      <= 8'd255;
            game_over_q     <= 2'b00;
`endif
        end else begin
            idx_q           <= idx_d;
            p_best_q        <= p_best_d;
            e_best_q        <= e_best_d;
            p_idx_q         <= p_idx_d;
            e_idx_q         <= e_idx_d;
            p_found_q       <= p_found_d;
            e_found_q       <= e_found_d;
            p_acc_q         <= p_acc_d;
            e_acc_q         <= e_acc_d;
            player_front_q  <= player_front_d;
            enemy_front_q   <= enemy_front_d;
            dmg_to_player_q <= dmg_to_player_d;
            dmg_to_enemy_q  <= dmg_to_enemy_d;
            p_scen_q        <= p_scen_d;
            e_scen_q        <= e_scen_d;
            move_q          <= move_d;
            busy_q          <= busy_d;
`ifdef BATTLEFRONT_BASE_DMG_EN
            p_health_q      <= p_health_d;
            e_health_q      <= e_health_d;
            game_over_q     <= game_over_d;
`endif
        end
    end

    assign playerFront      = player_front_q;
    assign enemyFront       = enemy_front_q;
    assign dmgToPlayer      = dmg_to_player_q;
    assign dmgToEnemy       = dmg_to_enemy_q;
    assign playerDamageSCEN = p_scen_q;
    assign enemyDamageSCEN  = e_scen_q;
    assign moveSCEN         = move_q;
    assign busy             = busy_q;
`ifdef BATTLEFRONT_BASE_DMG_EN
    assign playerBaseHealth = p_health_q;
    assign enemyBaseHealth  = e_health_q;
    assign gameOver         = game_over_q;
`endif

endmodule

// File: tb/tb_battlefront_calc.sv
// Directed bench for battlefront_calc: per-cycle compare against a round-level model plus literal checks.
module tb_battlefront_calc;

    localparam int N  = 4;
    localparam int FM = 480;

    logic clk = 1'b0;
    logic reset;
    logic gameClk;
    logic [8:0] p_pos [N];
    logic [1:0] p_typ [N];
    logic [7:0] p_dmg [N];
    logic [8:0] e_pos [N];
    logic [1:0] e_typ [N];
    logic [7:0] e_dmg [N];
    logic [9*N-1:0] playerPos, enemyPos;
    logic [2*N-1:0] playerType, enemyType;
    logic [8*N-1:0] playerDmg, enemyDmg;
    logic [8:0] playerFront, enemyFront;
    logic [7:0] dmgToPlayer, dmgToEnemy;
    logic [N-1:0] playerDamageSCEN, enemyDamageSCEN;
    logic moveSCEN, busy;
`ifdef BATTLEFRONT_BASE_DMG_EN
    logic [7:0] playerBaseHealth, enemyBaseHealth;
    logic [1:0] gameOver;
`endif

    int vecs = 0;
    int errs = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign playerPos[9*g +: 9]  = p_pos[g];
        assign playerType[2*g +: 2] = p_typ[g];
        assign playerDmg[8*g +: 8]  = p_dmg[g];
        assign enemyPos[9*g +: 9]   = e_pos[g];
        assign enemyType[2*g +: 2]  = e_typ[g];
        assign enemyDmg[8*g +: 8]   = e_dmg[g];
    end

    battlefront_calc #(.NUM_UNITS(N), .FIELD_MAX(9'd480)) dut (
        .clk(clk), .reset(reset), .gameClk(gameClk),
        .playerPos(playerPos), .playerType(playerType), .playerDmg(playerDmg),
        .enemyPos(enemyPos), .enemyType(enemyType), .enemyDmg(enemyDmg),
        .playerFront(playerFront), .enemyFront(enemyFront),
        .dmgToPlayer(dmgToPlayer), .dmgToEnemy(dmgToEnemy),
        .playerDamageSCEN(playerDamageSCEN), .enemyDamageSCEN(enemyDamageSCEN),
        .moveSCEN(moveSCEN),
`ifdef BATTLEFRONT_BASE_DMG_EN
        .playerBaseHealth(playerBaseHealth), .enemyBaseHealth(enemyBaseHealth), .gameOver(gameOver),
`endif
        .busy(busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Round-level model: which unit is in front, what each side deals, and when.
    function automatic int front_of(input bit pl);
        int best = -1;
        for (int i = 0; i < N; i++) begin
            if (pl && p_typ[i] != 2'b00) begin
                if (best < 0 || p_pos[i] < p_pos[best]) best = i;
            end
            if (!pl && e_typ[i] != 2'b00) begin
                if (best < 0 || e_pos[i] > e_pos[best]) best = i;
            end
        end
        return best;
    endfunction

    function automatic int front_pos(input bit pl);
        int idx = front_of(pl);
        if (idx < 0) return pl ? FM : 0;
        return pl ? int'(p_pos[idx]) : int'(e_pos[idx]);
    endfunction

    function automatic int dmg_sum(input bit pl);
        int s = 0;
        for (int i = 0; i < N; i++) begin
            if (pl && p_typ[i] != 2'b00) s += int'(p_dmg[i]);
            if (!pl && e_typ[i] != 2'b00) s += int'(e_dmg[i]);
        end
        return (s > 255) ? 255 : s;
    endfunction

    function automatic logic [N-1:0] strobe(input int idx, input int dmg);
        logic [N-1:0] r = '0;
        if (idx >= 0 && dmg != 0) r[idx] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] sub_sat(input logic [7:0] a, input logic [7:0] b);
        return (b > a) ? 8'd0 : a - b;
    endfunction

    // mk = cycles since the accepted tick edge (0 = idle).
    int mk = 0;
    logic m_prev;
    logic [8:0] m_pf, m_ef;
    logic [7:0] m_dp, m_de, m_ph, m_eh;
    logic [N-1:0] m_ps, m_es;
    logic [1:0] m_go;

    always @(posedge clk) begin
        m_prev <= gameClk;
        if (reset) begin
            mk <= 0;
            m_pf <= 9'd480; m_ef <= 9'd0; m_dp <= 8'd0; m_de <= 8'd0;
            m_ps <= '0; m_es <= '0;
            m_ph <= 8'd255; m_eh <= 8'd255; m_go <= 2'b00;
        end else begin
            if (mk == 0) mk <= (gameClk && !m_prev && m_go == 2'b00) ? 1 : 0;
            else if (mk == N + 2) mk <= 0;
            else mk <= mk + 1;
            if (mk == N) begin
                m_pf <= 9'(front_pos(1));
                m_ef <= 9'(front_pos(0));
                m_dp <= 8'(dmg_sum(0));
                m_de <= 8'(dmg_sum(1));
                m_ps <= strobe(front_of(1), dmg_sum(0));
                m_es <= strobe(front_of(0), dmg_sum(1));
            end else begin
                m_ps <= '0;
                m_es <= '0;
            end
`ifdef BATTLEFRONT_BASE_DMG_EN
            if (mk == N + 1) begin
                if (front_of(0) < 0) begin
                    m_eh <= sub_sat(m_eh, m_de);
                    if (sub_sat(m_eh, m_de) == 8'd0) m_go[1] <= 1'b1;
                end
                if (front_of(1) < 0) begin
                    m_ph <= sub_sat(m_ph, m_dp);
                    if (sub_sat(m_ph, m_dp) == 8'd0) m_go[0] <= 1'b1;
                end
            end
`endif
        end
    end

    // Every-cycle compare of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("playerFront", int'(playerFront), int'(m_pf));
            chk("enemyFront", int'(enemyFront), int'(m_ef));
            chk("dmgToPlayer", int'(dmgToPlayer), int'(m_dp));
            chk("dmgToEnemy", int'(dmgToEnemy), int'(m_de));
            chk("playerDamageSCEN", int'(playerDamageSCEN), int'(m_ps));
            chk("enemyDamageSCEN", int'(enemyDamageSCEN), int'(m_es));
            chk("moveSCEN", int'(moveSCEN), (mk == N + 2) ? 1 : 0);
            chk("busy", int'(busy), (mk != 0) ? 1 : 0);
`ifdef BATTLEFRONT_BASE_DMG_EN
            chk("playerBaseHealth", int'(playerBaseHealth), int'(m_ph));
            chk("enemyBaseHealth", int'(enemyBaseHealth), int'(m_eh));
            chk("gameOver", int'(gameOver), int'(m_go));
`endif
        end
    end

    int mv_cnt, mv_at, sc_at, busy_cnt;
    logic [N-1:0] ps_seen, es_seen;
    int snap_pf, snap_ef, snap_dp, snap_de, snap_busy;

    // Raise gameClk in cycle T; observation c is taken mid-cycle T+c.
    task automatic run_tick(input int hold, input int retick, input int rst_at, input int win);
        mv_cnt = 0; mv_at = -1; sc_at = -1; busy_cnt = 0; ps_seen = '0; es_seen = '0;
        @(posedge clk); #2;
        gameClk = 1'b1;
        for (int c = 0; c < win; c++) begin
            @(negedge clk);
            if (moveSCEN) begin mv_cnt++; mv_at = c; end
            if (playerDamageSCEN != '0 || enemyDamageSCEN != '0) begin
                ps_seen = playerDamageSCEN; es_seen = enemyDamageSCEN; sc_at = c;
            end
            if (busy) busy_cnt++;
            if (c == rst_at + 1) begin
                snap_pf = int'(playerFront); snap_ef = int'(enemyFront);
                snap_dp = int'(dmgToPlayer); snap_de = int'(dmgToEnemy); snap_busy = int'(busy);
            end
            if (c == hold) gameClk = 1'b0;
            if (retick != 0 && c == retick) gameClk = 1'b1;
            if (retick != 0 && c == retick + 1) gameClk = 1'b0;
            if (rst_at != 0 && c == rst_at) reset = 1'b1;
            if (rst_at != 0 && c == rst_at + 1) reset = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        gameClk = 1'b0;
        for (int i = 0; i < N; i++) begin
            p_pos[i] = 9'd100; p_typ[i] = 2'b00; p_dmg[i] = 8'd7;
            e_pos[i] = 9'd0;   e_typ[i] = 2'b00; e_dmg[i] = 8'd32;
        end
        @(posedge clk); #2;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        // Idle after reset: bases as fronts, no strobes.
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_moveSCEN", int'(moveSCEN), 0);
            chk("idle_busy", int'(busy), 0);
        end
        chk("idle_playerFront", int'(playerFront), 480);
        chk("idle_enemyFront", int'(enemyFront), 0);

        // Enemies 10/50/50/(dead 0), 32 each; players dead.
        e_pos[0] = 9'd10; e_pos[1] = 9'd50; e_pos[2] = 9'd50; e_pos[3] = 9'd0;
        e_typ[0] = 2'b01; e_typ[1] = 2'b01; e_typ[2] = 2'b01; e_typ[3] = 2'b00;
        run_tick(1, 0, 0, 12);
        chk("t2_enemyFront", int'(enemyFront), 50);
        chk("t2_dmgToPlayer", int'(dmgToPlayer), 96);
        chk("t2_playerFront", int'(playerFront), 480);
        chk("t2_playerSCEN", int'(ps_seen), 0);
        chk("t2_strobe_cycle", sc_at, -1);
        chk("t2_move_at", mv_at, 6);
        chk("t2_move_cnt", mv_cnt, 1);
        chk("t2_busy_cycles", busy_cnt, 6);
        chk("t2_model_ef", int'(m_ef), 50);

        // One player at 300 dealing 5: tie-broken enemy slot 1 takes the hit.
        p_typ[0] = 2'b01; p_pos[0] = 9'd300; p_dmg[0] = 8'd5;
        run_tick(1, 0, 0, 12);
        chk("t2b_enemySCEN", int'(es_seen), 2);
        chk("t2b_playerSCEN", int'(ps_seen), 1);
        chk("t2b_strobe_cycle", sc_at, 5);
        chk("t2b_dmgToEnemy", int'(dmgToEnemy), 5);

        // Players 300/200 dealing 200 each; single live enemy at 120 in slot 2.
        p_typ[0] = 2'b10; p_pos[0] = 9'd300; p_dmg[0] = 8'd200;
        p_typ[1] = 2'b10; p_pos[1] = 9'd200; p_dmg[1] = 8'd200;
        e_typ[0] = 2'b00; e_typ[1] = 2'b00; e_typ[2] = 2'b01;
        e_pos[2] = 9'd120; e_dmg[2] = 8'd10;
        run_tick(1, 0, 0, 12);
        chk("t3_dmgToEnemy", int'(dmgToEnemy), 255);
        chk("t3_enemySCEN", int'(es_seen), 4);
        chk("t3_strobe_cycle", sc_at, 5);
        chk("t3_playerFront", int'(playerFront), 200);
        chk("t3_playerSCEN", int'(ps_seen), 2);
        chk("t3_enemyFront", int'(enemyFront), 120);
        chk("t3_dmgToPlayer", int'(dmgToPlayer), 10);
        chk("t3_model_de", int'(m_de), 255);

        // Re-tick during a round is dropped.
        run_tick(1, 2, 0, 14);
        chk("t4_move_cnt", mv_cnt, 1);
        chk("t4_busy_cycles", busy_cnt, 6);

        // gameClk held high for 100 cycles: one round.
        run_tick(100, 0, 0, 110);
        chk("t5_move_cnt", mv_cnt, 1);
        chk("t5_busy_cycles", busy_cnt, 6);

        // Reset at T+3 aborts the round.
        run_tick(1, 0, 3, 12);
        chk("t6_move_cnt", mv_cnt, 0);
        chk("t6_strobe_cycle", sc_at, -1);
        chk("t6_pf_T4", snap_pf, 480);
        chk("t6_ef_T4", snap_ef, 0);
        chk("t6_dp_T4", snap_dp, 0);
        chk("t6_de_T4", snap_de, 0);
        chk("t6_busy_T4", snap_busy, 0);
        chk("t6_busy_cycles", busy_cnt, 3);

        // No enemies, players dealing 100 in total.
        p_typ[1] = 2'b00; p_dmg[0] = 8'd100;
        e_typ[2] = 2'b00;
        run_tick(1, 0, 0, 12);
        chk("t7_dmgToEnemy", int'(dmgToEnemy), 100);
        chk("t7_enemySCEN", int'(es_seen), 0);
        chk("t7_enemyFront", int'(enemyFront), 0);
`ifdef BATTLEFRONT_BASE_DMG_EN
        chk("t7_enemyBase1", int'(enemyBaseHealth), 155);
        run_tick(1, 0, 0, 12);
        chk("t7_enemyBase2", int'(enemyBaseHealth), 55);
        run_tick(1, 0, 0, 12);
        chk("t7_enemyBase3", int'(enemyBaseHealth), 0);
        chk("t7_gameOver", int'(gameOver), 2);
        chk("t7_playerBase", int'(playerBaseHealth), 255);
        run_tick(1, 0, 0, 12);
        chk("t7_halted_busy", busy_cnt, 0);
        chk("t7_halted_move", mv_cnt, 0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
